// File: rtl/mw_wb_stage.sv
// M/W pipeline register with load extraction and GRF writeback formation.
// One cycle M->W; en=0 holds every register (stall), clr loads a bubble (flush).
module mw_wb_stage #(
   parameter logic [31:0] LINK_OFS = 32'd8,
   parameter logic [4:0]  RA_IDX   = 5'd31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   input  logic        M_valid,
   input  logic [31:0] M_instr,
   input  logic [31:0] M_pc,
   input  logic [31:0] M_result,
   input  logic [31:0] M_rdata,
   output logic [31:0] W_instr,
   output logic [31:0] W_pc,
   output logic [4:0]  W_A3,
   output logic [31:0] W_WD,
   output logic        W_we,
   output logic        W_valid,
   output logic        W_err,
   output logic [31:0] W_retired
);

   logic [31:0] instr_q, instr_d, pc_q, pc_d, wd_q, wd_d, retired_q, retired_d;
   logic [4:0]  a3_q, a3_d;
   logic        we_q, we_d, valid_q, valid_d, err_q, err_d;

   logic [5:0]  op, func;
   logic [4:0]  rt, rd, dst;
   logic [1:0]  a;
   logic        is_lw, is_lb, is_lbu, is_lh, is_lhu, is_load, is_link, misalign, writes;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data, wb_data;

   assign op   = M_instr[31:26];
   assign func = M_instr[5:0];
   assign rt   = M_instr[20:16];
   assign rd   = M_instr[15:11];
   assign a    = M_result[1:0];

   assign is_lw   = (op == 6'b100011);
   assign is_lb   = (op == 6'b100000);
   assign is_lbu  = (op == 6'b100100);
   assign is_lh   = (op == 6'b100001);
   assign is_lhu  = (op == 6'b100101);
   assign is_load = is_lw | is_lb | is_lbu | is_lh | is_lhu;
   assign is_link = (op == 6'b000011) || (op == 6'b000001 && (rt == 5'b10000 || rt == 5'b10001))
                 || (op == 6'b000000 && func == 6'b001001);

   // Misalignment only matters for a real instruction; bubbles never raise W_err.
   assign misalign = M_valid && ((is_lw && a != 2'b00) || ((is_lh || is_lhu) && a[0]));

   always_comb begin
      dst = 5'd0;
      if (op == 6'b000000) begin
         case (func)
            6'b100001, 6'b100011, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000100,
            6'b000010, 6'b000110, 6'b000011, 6'b000111, 6'b010000, 6'b010010,
            6'b001001: dst = rd;
            default:   dst = 5'd0;
         endcase
      end else if (op == 6'b000011 || (op == 6'b000001 && (rt == 5'b10000 || rt == 5'b10001))) begin
         dst = RA_IDX;
      end else begin
         case (op)
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
            6'b001010, 6'b001011, 6'b100011, 6'b100000, 6'b100100, 6'b100001,
            6'b100101: dst = rt;
            default:   dst = 5'd0;
         endcase
      end
   end

   assign ld_byte = 8'(M_rdata >> {a, 3'b000});
   assign ld_half = a[1] ? M_rdata[31:16] : M_rdata[15:0];

   always_comb begin
      ld_data = M_rdata;
      if (is_lb)       ld_data = {{24{ld_byte[7]}}, ld_byte};
      else if (is_lbu) ld_data = {24'd0, ld_byte};
      else if (is_lh)  ld_data = {{16{ld_half[15]}}, ld_half};
      else if (is_lhu) ld_data = {16'd0, ld_half};
   end

   assign wb_data = is_link ? (M_pc + LINK_OFS) : (is_load ? ld_data : M_result);
   assign writes  = (dst != 5'd0) && !misalign;

   always_comb begin
      instr_d   = instr_q;
      pc_d      = pc_q;
      a3_d      = a3_q;
      wd_d      = wd_q;
      we_d      = we_q;
      valid_d   = valid_q;
      err_d     = err_q;
      retired_d = retired_q;
      if (clr || (en && !M_valid)) begin
         instr_d = 32'd0;
         pc_d    = 32'd0;
         a3_d    = 5'd0;
         wd_d    = 32'd0;
         we_d    = 1'b0;
         valid_d = 1'b0;
      end else if (en) begin
         instr_d = M_instr;
         pc_d    = M_pc;
         a3_d    = writes ? dst : 5'd0;
         wd_d    = writes ? wb_data : 32'd0;
         we_d    = writes;
         valid_d = 1'b1;
         err_d   = err_q | misalign;
         if (!misalign) retired_d = retired_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_q   <= 32'd0;
         pc_q      <= 32'd0;
         a3_q      <= 5'd0;
         wd_q      <= 32'd0;
         we_q      <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         retired_q <= 32'd0;
      end else begin
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         a3_q      <= a3_d;
         wd_q      <= wd_d;
         we_q      <= we_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         retired_q <= retired_d;
      end
   end

   assign W_instr   = instr_q;
   assign W_pc      = pc_q;
   assign W_A3      = a3_q;
   assign W_WD      = wd_q;
   assign W_we      = we_q;
   assign W_valid   = valid_q;
   assign W_err     = err_q;
   assign W_retired = retired_q;

endmodule

// File: tb/tb_mw_wb_stage.sv
// Directed-vector bench for mw_wb_stage with hand-computed expectations.
module tb_mw_wb_stage;

   logic        clk = 1'b0;
   logic        reset, en, clr, M_valid;
   logic [31:0] M_instr, M_pc, M_result, M_rdata;
   logic [31:0] W_instr, W_pc, W_WD, W_retired;
   logic [4:0]  W_A3;
   logic        W_we, W_valid, W_err;

   int n_vec = 0;
   int n_miss = 0;

   mw_wb_stage dut (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .M_valid(M_valid),
      .M_instr(M_instr), .M_pc(M_pc), .M_result(M_result), .M_rdata(M_rdata),
      .W_instr(W_instr), .W_pc(W_pc), .W_A3(W_A3), .W_WD(W_WD), .W_we(W_we),
      .W_valid(W_valid), .W_err(W_err), .W_retired(W_retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Checks the writeback triple plus valid/err/retired in one call.
   task automatic chk_w(input string tag, input logic [4:0] a3, input logic [31:0] wd,
                        input logic we, input logic vld, input logic err, input logic [31:0] ret);
      chk({tag, ".A3"},      {27'd0, W_A3}, {27'd0, a3});
      chk({tag, ".WD"},      W_WD, wd);
      chk({tag, ".we"},      {31'd0, W_we}, {31'd0, we});
      chk({tag, ".valid"},   {31'd0, W_valid}, {31'd0, vld});
      chk({tag, ".err"},     {31'd0, W_err}, {31'd0, err});
      chk({tag, ".retired"}, W_retired, ret);
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] res);
      M_valid  = 1'b1;
      M_instr  = instr;
      M_pc     = pc;
      M_result = res;
   endtask

   initial begin
      reset = 1'b0; en = 1'b1; clr = 1'b0;
      M_rdata = 32'h80FF7F01;
      drive(32'h34080005, 32'h00003000, 32'h00000005);
      cyc(); cyc();
      chk("rst.instr", W_instr, 32'd0);
      chk("rst.pc", W_pc, 32'd0);
      chk_w("rst", 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

      reset = 1'b1;
      cyc();
      chk("ori.instr", W_instr, 32'h34080005);
      chk("ori.pc", W_pc, 32'h00003000);
      chk_w("ori", 5'd8, 32'h5, 1'b1, 1'b1, 1'b0, 32'd1);

      drive(32'h80090000, 32'h00003004, 32'h00001003); cyc();
      chk_w("lb", 5'd9, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 32'd2);
      drive(32'h900A0000, 32'h00003008, 32'h00001000); cyc();
      chk_w("lbu", 5'd10, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'd3);
      drive(32'h840B0000, 32'h0000300C, 32'h00001002); cyc();
      chk_w("lh", 5'd11, 32'hFFFF80FF, 1'b1, 1'b1, 1'b0, 32'd4);
      drive(32'h940C0000, 32'h00003010, 32'h00001000); cyc();
      chk_w("lhu", 5'd12, 32'h00007F01, 1'b1, 1'b1, 1'b0, 32'd5);

      drive(32'h0C000C00, 32'h00003000, 32'hDEADBEEF); cyc();
      chk_w("jal", 5'd31, 32'h00003008, 1'b1, 1'b1, 1'b0, 32'd6);
      drive(32'h03E00009, 32'h00003020, 32'h00000000); cyc();
      chk_w("jalr0", 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd7);
      drive(32'h04110004, 32'hFFFFFFFC, 32'h00000000); cyc();
      chk_w("bgezal", 5'd31, 32'h00000004, 1'b1, 1'b1, 1'b0, 32'd8);
      drive(32'hAC080000, 32'h00003028, 32'h00001000); cyc();
      chk_w("sw", 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd9);

      drive(32'h012A6821, 32'h0000302C, 32'h00001234); cyc();
      chk_w("addu", 5'd13, 32'h00001234, 1'b1, 1'b1, 1'b0, 32'd10);

      en = 1'b0;
      drive(32'h34080077, 32'h00004000, 32'h00000077);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_w("stall", 5'd13, 32'h00001234, 1'b1, 1'b1, 1'b0, 32'd10);
      end
      chk("stall.pc", W_pc, 32'h0000302C);

      clr = 1'b1; cyc();
      chk("flush.instr", W_instr, 32'd0);
      chk_w("flush", 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd10);

      clr = 1'b0; en = 1'b1;
      drive(32'h8C080000, 32'h00003030, 32'h00000002); cyc();
      chk_w("mis_lw", 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd10);
      drive(32'h012A6821, 32'h00003034, 32'h00000055); cyc();
      chk_w("after_mis", 5'd13, 32'h00000055, 1'b1, 1'b1, 1'b1, 32'd11);
      drive(32'h94080000, 32'h00003038, 32'h00000003); cyc();
      chk_w("mis_lhu", 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd11);

      M_valid = 1'b0; cyc();
      chk_w("bubble", 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd11);

      en = 1'b0;
      force dut.retired_q = 32'hFFFFFFFF;
      cyc();
      release dut.retired_q;
      cyc();
      chk("preload", W_retired, 32'hFFFFFFFF);
      en = 1'b1;
      drive(32'h012A6821, 32'h0000303C, 32'h00000001); cyc();
      chk_w("wrap", 5'd13, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'd0);

      en = 1'b0; reset = 1'b0; cyc();
      chk("rst2.instr", W_instr, 32'd0);
      chk_w("rst2", 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mw_wb_stage.md
Name: mw_wb_stage

Overview:
- M/W pipeline register plus writeback formation for the P6 five-stage MIPS core.
- Captures the instruction leaving the Memory stage.
- Performs load byte/halfword extraction and extension, and selects writeback data (load / ALU-or-HI/LO result / link address).
- Presents registered GRF write controls (W_A3, W_WD, W_we) and the W-stage instruction for the W-stage decoder and forwarding logic. Also keeps a retired-instruction counter and a sticky misalignment flag.

Parameters:
- LINK_OFS, 8, byte offset added to M_pc for link writes (jal/jalr/bltzal/bgezal).
- RA_IDX, 31, register index for jal/bltzal/bgezal link.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- en  in  1  1 = capture M inputs; 0 = hold all stage registers (stall)
- clr  in  1  1 = load a bubble (flush)
- M_valid  in  1  M-stage slot holds a real instruction
- M_instr  in  32  M-stage instruction word
- M_pc  in  32  M-stage PC
- M_result  in  32  ALU / HI-LO result (also the load/store address)
- M_rdata  in  32  aligned word read from DM at {M_result[31:2],2'b00}
- W_instr  out  32  registered instruction for the W-stage decoder
- W_pc  out  32  registered PC
- W_A3  out  5  GRF write index; 0 when not writing
- W_WD  out  32  GRF write data
- W_we  out  1  GRF write enable
- W_valid  out  1  W slot holds a real instruction
- W_err  out  1  sticky misaligned-load flag
- W_retired  out  32  count of retired instructions

Behaviour:
- Reset (reset==0 at edge): every output and internal register goes to 0. This includes W_retired and W_err. Reset overrides en and clr, including reset asserted mid-stall.
- Priority each edge: reset > clr > en. clr==1 loads a bubble even when en==0. Bubble = all outputs 0 except W_retired and W_err, which hold.
- en==1, clr==0, M_valid==0: load a bubble.
- en==1, clr==0, M_valid==1: capture the instruction. W_instr←M_instr, W_pc←M_pc, W_valid←1. W_A3, W_WD and W_we are computed combinationally from M inputs and registered the same edge. Latency is one cycle from M to W.
- en==0, clr==0: all stage registers hold. Counter and flag hold.
- Destination decode (op=[31:26], func=[5:0]):
  - A3=rd for op 000000 with func in {addu 100001, subu 100011, add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, sll 000000, sllv 000100, srl 000010, srlv 000110, sra 000011, srav 000111, mfhi 010000, mflo 010010, jalr 001001}.
  - A3=rt for op in {addi 001000, addiu 001001, andi 001100, ori 001101, xori 001110, lui 001111, slti 001010, sltiu 001011, lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101}.
  - A3=RA_IDX for jal 000011, and for op 000001 with rt in {10000, 10001}.
  - All else (stores, branches, j, jr, mult/div, mthi/mtlo, op 011100, unknown): no write, A3=0.
- Write-data select:
  - link instructions: WD=M_pc+LINK_OFS (32-bit wrap).
  - loads: WD=extracted load data.
  - others: WD=M_result.
- Load extraction, with a = M_result[1:0]:
  - lw: word.
  - lb/lbu: byte a, bits [8a+7:8a], sign- / zero-extended.
  - lh/lhu: half a[1], bits [16a[1]+15:16a[1]], sign- / zero-extended.
- Misalignment:
  - Condition: lw with a!=0, or lh/lhu with a[0]==1.
  - Effect: captured with W_we=0, W_A3=0, W_WD=0, W_valid=1. W_err is set and stays set until reset. The instruction is not counted.
- Write-enable: W_we=1 only when the instruction writes, A3!=0, and it is not misaligned. When W_we=0, W_A3 and W_WD are 0. nop (0x00000000) therefore yields W_we=0.
- W_retired increments by 1, wrapping at 2^32, on each capture with M_valid==1 that is not misaligned. It does not increment on bubbles, on holds, or under clr.

Test Plan:
- Reset with inputs active: reset=0 for 2 cycles, en=1, M_valid=1, M_instr=ori $t0 (0x34080005) -> all outputs 0. First capture after reset=1 gives W_A3=8, W_WD=M_result, W_we=1, W_retired=1.
- Loads: M_rdata=0x80FF7F01.
  - lb with M_result=0x...03 -> W_WD=0xFFFFFF80.
  - lbu at offset 0 -> 0x00000001.
  - lh at offset 2 -> 0xFFFF80FF.
  - lhu at offset 0 -> 0x00007F01.
- Link: jal at M_pc=0x00003000 -> W_A3=31, W_WD=0x00003008. jalr rd=0 -> W_we=0, W_A3=0.
- Stall/flush: en=0 for 3 cycles -> outputs and W_retired frozen. Then en=0 with clr=1 -> bubble (W_valid=0, W_we=0) and W_retired unchanged.
- Misalign: lw with M_result=0x00000002 -> W_we=0, W_err=1, W_retired unchanged. A following valid addu keeps W_err=1 until reset.
- Counter wrap: force 2^32-1 prior retires (or preload via a bench backdoor), then one valid addu -> W_retired=0.
